// File: rtl/codec_i2c_master_pkg.sv
// Shared types and constants for the WM8731 I2C control-word master.
package codec_i2c_master_pkg;

    localparam logic [7:0] WM8731_I2C_ADDR = 8'h34;
    localparam int         I2C_BYTES       = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } i2c_state_e;

    typedef struct packed {
        logic scl;
        logic oe;
    } bus_lvl_t;

    // Bus levels for a given state and quarter phase; msb is the data bit on the wire.
    function automatic bus_lvl_t bus_levels(i2c_state_e st, logic [1:0] ph, logic msb);
        bus_lvl_t lv;
        lv.scl = 1'b1;
        lv.oe  = 1'b0;
        case (st)
            ST_START: lv.oe = ph[1];
            ST_DATA: begin
                lv.scl = ph[1];
                lv.oe  = ~msb;
            end
            ST_ACK:   lv.scl = ph[1];
            ST_STOP: begin
                lv.scl = ph[1];
                lv.oe  = (ph != 2'd3);
            end
            default: ;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/codec_i2c_master_if.sv
// Packet handshake from the codec Avalon slave plus the two-wire pad signals.
interface codec_i2c_master_if;
    logic        wr_i2c;
    logic [23:0] i2c_packet;
    logic        i2c_idle;
    logic        ack_error;
    logic        i2c_sclk;
    logic        i2c_sdat_oe;
    logic        i2c_sdat_i;

    modport master (
        input  wr_i2c, i2c_packet, i2c_sdat_i,
        output i2c_idle, ack_error, i2c_sclk, i2c_sdat_oe
    );

    modport slave (
        output wr_i2c, i2c_packet, i2c_sdat_i,
        input  i2c_idle, ack_error, i2c_sclk, i2c_sdat_oe
    );
endinterface

// File: rtl/codec_i2c_tick.sv
// Quarter-SCL-period divider: pulses tick on the last of every CLK_DIV enabled cycles.
module codec_i2c_tick #(
    parameter int CLK_DIV = 125
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or posedge Rst_n) begin
        if (Rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/codec_i2c_master.sv
// Write-only I2C master: each accepted packet becomes START, three bytes with ACK slots, STOP.
module codec_i2c_master
    import codec_i2c_master_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic               Clk,
    input  logic               Rst_n,
    codec_i2c_master_if.master bus
);
    i2c_state_e  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [23:0] shreg_q, shreg_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [1:0]  sync_q, sync_d;
    logic        smp_q, smp_d;
    logic        ack_err_q, ack_err_d;
    logic        idle_q, idle_d;
    logic        scl_q, scl_d;
    logic        oe_q, oe_d;
    logic        tick;
    logic        slot_end;
    bus_lvl_t    lvl;

    codec_i2c_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .en   (state_q != ST_IDLE),
        .clr  (state_q == ST_IDLE),
        .tick (tick)
    );

    assign slot_end = tick && (phase_q == 2'd3);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        shreg_d   = shreg_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        smp_d     = smp_q;
        ack_err_d = ack_err_q;
        sync_d    = {sync_q[0], bus.i2c_sdat_i};
        idle_d    = (state_q == ST_IDLE);

        if (tick)
            phase_d = phase_q + 2'd1;
        // SDA is sampled on the q2->q3 boundary, mid SCL-high.
        if (tick && phase_q == 2'd2)
            smp_d = sync_q[1];

        case (state_q)
            ST_IDLE: begin
                if (bus.wr_i2c && idle_q) begin
                    shreg_d   = bus.i2c_packet;
                    ack_err_d = 1'b0;
                    phase_d   = 2'd0;
                    bit_d     = 3'd0;
                    byte_d    = 2'd0;
                    state_d   = ST_START;
                end
            end
            ST_START: if (slot_end) state_d = ST_DATA;
            ST_DATA: begin
                if (slot_end) begin
                    shreg_d = {shreg_q[22:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (slot_end) begin
                    byte_d = byte_q + 2'd1;
                    if (smp_q) begin
                        ack_err_d = 1'b1;
                        state_d   = ST_STOP;
                    end else if (byte_q == 2'(I2C_BYTES - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_STOP: if (slot_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Pad levels follow the next state so they change exactly on the slot/phase edge.
        lvl  = bus_levels(state_d, phase_d, shreg_d[23]);
        scl_d = lvl.scl;
        oe_d  = lvl.oe;
    end

    always_ff @(posedge Clk or posedge Rst_n) begin
        if (Rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            shreg_q   <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            sync_q    <= '0;
            smp_q     <= 1'b0;
            ack_err_q <= 1'b0;
            idle_q    <= 1'b1;
            scl_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            shreg_q   <= shreg_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            sync_q    <= sync_d;
            smp_q     <= smp_d;
            ack_err_q <= ack_err_d;
            idle_q    <= idle_d;
            scl_q     <= scl_d;
            oe_q      <= oe_d;
        end
    end

    assign bus.i2c_idle    = idle_q;
    assign bus.ack_error   = ack_err_q;
    assign bus.i2c_sclk    = scl_q;
    assign bus.i2c_sdat_oe = oe_q;

endmodule

// File: tb/tb_codec_i2c_master.sv
// Scoreboard bench: driver queues expected transactions, a bus monitor/slave decodes and compares.
module tb_codec_i2c_master;
    import codec_i2c_master_pkg::*;

    localparam int CLK_DIV = 4;

    typedef struct {
        logic [23:0] pkt;
        int          nack;
        int          dur;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    codec_i2c_master_if bus_if();
    logic slave_pull = 1'b0;
    assign bus_if.i2c_sdat_i = ~(bus_if.i2c_sdat_oe | slave_pull);

    codec_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus_if)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   free_at  = 0;
    int   cur_nack = 0;
    exp_t exp_q[$];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- bus monitor + slave model ----------------
    logic       m_prev_scl  = 1'b1;
    logic       m_prev_sda  = 1'b1;
    logic       m_prev_idle = 1'b1;
    logic [7:0] cur_byte    = '0;
    logic [7:0] dec_q[$];
    int busy, starts, stops, viol, fcnt, rcnt, t_rise, t_fall;
    bit rise_ok, fall_ok;

    always @(negedge Clk) begin
        logic scl, sda, idle;
        exp_t e;
        int   nb;
        scl  = bus_if.i2c_sclk;
        sda  = bus_if.i2c_sdat_i;
        idle = bus_if.i2c_idle;
        if (Rst_n) begin
            m_prev_idle = 1'b1;
            rise_ok = 0; fall_ok = 0;
            fcnt = 0; rcnt = 0;
            slave_pull = 1'b0;
        end else begin
            if (m_prev_idle && !idle) begin
                busy = 0; starts = 0; stops = 0; viol = 0;
                dec_q.delete();
                check("ack_clear", 32'(bus_if.ack_error), 32'd0);
            end
            if (!idle) busy++;
            if (m_prev_scl && scl && m_prev_sda && !sda) begin
                starts++; fcnt = 0; rcnt = 0; rise_ok = 0; fall_ok = 0;
            end else if (m_prev_scl && scl && !m_prev_sda && sda) begin
                stops++; rise_ok = 0;
            end
            if (!m_prev_scl && scl) begin
                if (fall_ok && (cyc - t_fall) != 2 * CLK_DIV) viol++;
                t_rise = cyc; rise_ok = 1;
                if (rcnt % 9 < 8) cur_byte = {cur_byte[6:0], sda};
                if (rcnt % 9 == 7) dec_q.push_back(cur_byte);
                rcnt++;
            end
            if (m_prev_scl && !scl) begin
                if (rise_ok && (cyc - t_rise) != 2 * CLK_DIV) viol++;
                t_fall = cyc; fall_ok = 1;
                slave_pull = (fcnt % 9 == 8) && (cur_nack == 0 || (fcnt / 9) + 1 < cur_nack);
                fcnt++;
            end
            if (!m_prev_idle && idle) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_txn", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    nb = (e.nack == 0) ? I2C_BYTES : e.nack;
                    check("busy_cycles", busy, e.dur);
                    check("byte_count", dec_q.size(), nb);
                    for (int i = 0; i < nb && i < dec_q.size(); i++)
                        check($sformatf("byte%0d", i), 32'(dec_q[i]), (32'(e.pkt) >> (16 - 8 * i)) & 32'hFF);
                    check("ack_error", 32'(bus_if.ack_error), 32'(e.nack != 0));
                    check("start_stop", starts * 16 + stops, 32'h11);
                    check("scl_timing_viol", viol, 0);
                end
            end
            m_prev_idle = idle;
        end
        m_prev_scl = scl;
        m_prev_sda = sda;
    end

    // ---------------- driver with reference timing model ----------------
    task automatic issue(input logic [23:0] pkt, input int nack);
        int   n;
        exp_t e;
        @(negedge Clk);
        n = cyc + 1;
        if (n >= free_at) begin
            e.pkt  = pkt;
            e.nack = nack;
            e.dur  = (nack == 0) ? 116 * CLK_DIV : (2 + 9 * nack) * 4 * CLK_DIV;
            exp_q.push_back(e);
            cur_nack = nack;
            free_at  = n + 2 + e.dur;
        end
        bus_if.wr_i2c     = 1'b1;
        bus_if.i2c_packet = pkt;
        @(negedge Clk);
        bus_if.wr_i2c = 1'b0;
    endtask

    task automatic send(input logic [23:0] pkt, input int nack);
        while (cyc + 1 < free_at) @(negedge Clk);
        repeat ($urandom_range(0, 5)) @(negedge Clk);
        issue(pkt, nack);
    endtask

    initial begin
        int          toggles, drops, w, nack;
        logic        last_scl;
        logic [23:0] pkt;
        Rst_n = 1'b1;
        bus_if.wr_i2c     = 1'b0;
        bus_if.i2c_packet = '0;

        // Reset values and quiet idle bus
        repeat (3) @(negedge Clk);
        check("rst_idle", 32'(bus_if.i2c_idle), 32'd1);
        check("rst_scl", 32'(bus_if.i2c_sclk), 32'd1);
        check("rst_oe", 32'(bus_if.i2c_sdat_oe), 32'd0);
        check("rst_ack_error", 32'(bus_if.ack_error), 32'd0);
        Rst_n = 1'b0;
        toggles = 0; drops = 0;
        last_scl = bus_if.i2c_sclk;
        repeat (1000) begin
            @(negedge Clk);
            if (bus_if.i2c_sclk !== last_scl) toggles++;
            if (bus_if.i2c_idle !== 1'b1) drops++;
            last_scl = bus_if.i2c_sclk;
        end
        check("idle_scl_toggles", toggles, 0);
        check("idle_drops", drops, 0);

        // Full write, then NACK on the address byte, then a clean write clearing ack_error
        send({WM8731_I2C_ADDR, 16'h1E00}, 0);
        send({WM8731_I2C_ADDR, 16'h1E00}, 1);
        send({WM8731_I2C_ADDR, 16'h0C9F}, 0);

        // Write strobe while busy is ignored; the request is reissued after idle
        send({WM8731_I2C_ADDR, 16'h1234}, 0);
        repeat (9) @(negedge Clk);
        issue(24'h340C9F, 0);
        send(24'h340C9F, 0);

        // Reset during byte 2 abandons the transaction
        send({WM8731_I2C_ADDR, 16'hA55A}, 0);
        repeat (13 * 4 * CLK_DIV) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("midrst_scl", 32'(bus_if.i2c_sclk), 32'd1);
        check("midrst_oe", 32'(bus_if.i2c_sdat_oe), 32'd0);
        check("midrst_idle", 32'(bus_if.i2c_idle), 32'd1);
        exp_q.delete();
        free_at  = 0;
        cur_nack = 0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b0;
        send(24'h340812, 0);

        // Randomized packets and slave NACK positions
        for (int t = 0; t < 10; t++) begin
            pkt  = ($urandom_range(0, 3) == 0) ? 24'($urandom) : {WM8731_I2C_ADDR, 16'($urandom)};
            nack = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            send(pkt, nack);
        end

        w = 0;
        while (exp_q.size() > 0 && w < 200 * CLK_DIV) begin
            @(negedge Clk);
            w++;
        end
        check("drain_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
